// File: rtl/bk_mp_add_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package bk_mp_add_seq_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width of the word index; a single-word operand still needs one bit.
   function automatic int idx_width(input int nwords);
      return (nwords <= 1) ? 1 : $clog2(nwords);
   endfunction

endpackage

// File: rtl/bk_mp_add_seq_if.sv
// Request/response bundle between the issue logic (master) and the sequencer (slave).
interface bk_mp_add_seq_if
   import bk_mp_add_seq_pkg::*;
#(
   parameter int NWORDS = 4
) ();

   localparam int W = WORD_W * NWORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );

endinterface

// File: rtl/bk_mp_add_seq_bk32.sv
// 32-bit Brent-Kung parallel-prefix adder with carry-in, purely combinational.
module bk_32bit (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);

   // Up-sweep builds prefixes at positions 2^k-1, down-sweep fills in the rest.
   always_comb begin : prefix
      logic [31:0] hp;
      logic [31:0] gg;
      logic [31:0] pp;
      hp = a_i ^ b_i;
      gg = a_i & b_i;
      pp = hp;
      // Carry-in folded into bit 0, so gg[i] becomes the carry out of bit i.
      gg[0] = gg[0] | (hp[0] & cin_i);
      for (int lvl = 0; lvl < 5; lvl++) begin
         for (int i = (2 << lvl) - 1; i < 32; i += (2 << lvl)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
            pp[i] = pp[i] & pp[i - (1 << lvl)];
         end
      end
      for (int lvl = 3; lvl >= 0; lvl--) begin
         for (int i = (3 << lvl) - 1; i < 32; i += (2 << lvl)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
            pp[i] = pp[i] & pp[i - (1 << lvl)];
         end
      end
      sum_o  = hp ^ {gg[30:0], cin_i};
      cout_o = gg[31];
   end

endmodule

// File: rtl/bk_mp_add_seq.sv
// Multi-precision add/subtract: one 32-bit word per clock, LSW first, carry chained
// through a register around a single shared Brent-Kung adder.
module bk_mp_add_seq
   import bk_mp_add_seq_pkg::*;
#(
   parameter int NWORDS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   bk_mp_add_seq_if.slave   bus
);

   localparam int             IW       = idx_width(NWORDS);
   localparam logic [IW-1:0]  LAST_IDX = IW'(NWORDS - 1);

   state_e                          state_q, state_d;
   logic [IW-1:0]                   idx_q, idx_d;
   logic                            carry_q, carry_d;
   logic                            sub_q, sub_d;
   logic [NWORDS-1:0][WORD_W-1:0]   a_q, a_d;
   logic [NWORDS-1:0][WORD_W-1:0]   b_q, b_d;
   logic [NWORDS-1:0][WORD_W-1:0]   sum_q, sum_d;
   logic                            cout_q, cout_d;
   logic                            ovf_q, ovf_d;

   logic [WORD_W-1:0]               word_a;
   logic [WORD_W-1:0]               word_b;
   logic [WORD_W-1:0]               add_b;
   logic [WORD_W-1:0]               add_sum;
   logic                            add_cout;
   logic                            carry_into_msb;

   // Select the operand words for the current index.
   always_comb begin
      word_a = '0;
      word_b = '0;
      for (int k = 0; k < NWORDS; k++) begin
         if (idx_q == IW'(k)) begin
            word_a = a_q[k];
            word_b = b_q[k];
         end
      end
   end

   // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
   assign add_b = word_b ^ {WORD_W{sub_q}};

   bk_32bit u_add (
      .a_i    (word_a),
      .b_i    (add_b),
      .cin_i  (carry_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   assign carry_into_msb = word_a[WORD_W-1] ^ add_b[WORD_W-1] ^ add_sum[WORD_W-1];

   // Next-state and datapath update for the IDLE/RUN/DONE sequence.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               sub_d   = bus.in_sub;
               carry_d = bus.in_sub;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int k = 0; k < NWORDS; k++) begin
               if (idx_q == IW'(k)) sum_d[k] = add_sum;
            end
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout;
               ovf_d   = carry_into_msb ^ add_cout;
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: doc/bk_mp_add_seq.md
Name: bk_mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one shared 32-bit Brent-Kung adder (bk_32bit).
- Accepts NWORDS*32-bit operands over a valid/ready handshake.
- Processes one 32-bit word per clock, least significant word first, chaining the carry through a register.
- Returns the full sum, the carry-out and the signed overflow over a valid/ready handshake.
- Sits between the arithmetic issue logic and the result writeback path.

Parameters:
- NWORDS, 4, number of 32-bit words per operand (legal range >= 1; operand width W = 32*NWORDS).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_sub  input  1  0: A+B; 1: A-B, computed as A + ~B + 1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  W  result, registered.
- out_cout  output  1  final carry; in sub mode, 1 means no borrow.
- out_ovf  output  1  two's-complement signed overflow of the W-bit operation.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, while rst_n=0):
  - state=IDLE, word index=0, carry=0.
  - out_sum=0, out_cout=0, out_ovf=0, out_valid=0.
  - in_ready is decoded from state, so it reads 1 during and after reset.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch in_a, in_b and in_sub; set carry=in_sub; set index=0; go to RUN.
  - Operands need not stay stable after the accept edge.
- RUN, one word per cycle:
  - Adder inputs: a=A[idx], b=B[idx] XOR {32{sub}}, cin=carry.
  - At the edge: out_sum[idx] <= sum, carry <= cout, idx <= idx+1.
  - At idx=NWORDS-1, additionally:
    - out_cout <= cout.
    - out_ovf <= carry into bit 31 XOR cout, where carry into bit 31 = a31 ^ b'31 ^ sum31.
    - Go to DONE.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are held stable.
  - When out_ready=1 at an edge, go to IDLE.
  - A new request cannot be accepted in the same cycle; in_ready is 0 in DONE.
- Latency: out_valid rises NWORDS edges after the accept edge.
- Throughput: one operation per NWORDS+2 cycles when out_ready is held high.
- Handshake:
  - in_valid during RUN or DONE is ignored and not queued.
  - out_ready with out_valid=0 has no effect.
- out_sum words not yet written in the current operation keep their previous values. They are visible internally only; out_valid=0 during RUN.
- NWORDS=1: RUN lasts exactly one cycle.
- Index counter width = max(1, clog2(NWORDS)); it never wraps beyond NWORDS-1.
- Reset asserted mid-RUN or mid-DONE aborts the operation and discards partial results. The block returns to the reset values above.

Decomposition:
- Shared package contains:
  - WORD_W=32.
  - state enum {IDLE, RUN, DONE}.
  - a function for the index width derived from NWORDS.
- One sub-module instance: bk_32bit (existing adder), instantiated once and used combinationally per word.
- No other sub-modules.

Test Plan:
- NWORDS=4, A=all ones (128-bit), B=1, sub=0 -> out_sum=0, out_cout=1, out_ovf=0; out_valid exactly 4 edges after accept.
- A=0, B=1, sub=1 -> out_sum=all ones (0xFFFF...FFFF), out_cout=0 (borrow), out_ovf=0.
- A=0x7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1, sub=0 -> out_sum=0x8000_0000_0000_0000_0000_0000_0000_0000, out_ovf=1, out_cout=0.
- Hold out_ready=0 for 3 cycles in DONE while driving a new in_valid:
  - out_valid and out_sum stay stable; in_ready=0; second request not accepted.
  - After out_ready=1: IDLE, then the second request is accepted and computed correctly.
- Assert rst_n=0 after 2 RUN cycles:
  - outputs return to 0 and in_ready=1 immediately.
  - next request A=5, B=3, sub=1 -> out_sum=2, out_cout=1.
- NWORDS=1, A=0xFFFF_FFFF, B=0xFFFF_FFFF, sub=0 -> out_sum=0xFFFF_FFFE, out_cout=1, out_ovf=0; out_valid 1 edge after accept.
